// File: rtl/num_detector_seq.sv
`default_nettype none
// ============================================================================
// Module   : num_detector_seq
// Purpose  : Bit-serial divisibility detector. A captured unsigned number is
//            walked MSB first, one bit per clock. NDIV residue channels track
//            (number mod d_i) for d_i = i+2. When the last bit has been
//            consumed, LED shows which divisors divide the number.
// Ports    : clk      - single clock, rising edge
//            reset    - synchronous, active-high reset
//            start    - evaluation request, sampled only when not busy
//            num      - WIDTH-bit unsigned number, captured on accepted start
//            busy     - high during the WIDTH bit-processing cycles
//            done     - one-cycle pulse, LED carries a fresh result
//            LED      - LED[NDIV-1-i] = 1 iff num divisible by (i+2)
//            all_div  - (NUMDET_ALL_EN only) num divisible by every divisor
// Config   : define NUMDET_ALL_EN to add the all_div output and its register
// Revision : 1.0 - initial release
// ============================================================================
module num_detector_seq #(
  parameter int WIDTH = 8,
  parameter int NDIV  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             done,
  output logic [NDIV-1:0]  LED
`ifdef NUMDET_ALL_EN
  ,
  output logic             all_div
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      num_q, num_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NDIV-1:0][3:0]  res_q, res_d;
  logic [NDIV-1:0]       led_q, led_d;

  logic                  w_bit;
  logic [NDIV-1:0][3:0]  w_step;
  logic [NDIV-1:0]       w_zero;

  // The captured number is shifted left each SHIFT cycle, so the bit being
  // consumed is always the MSB of the shift register.
  assign w_bit = num_q[WIDTH-1];

  // Per-channel residue step. Since r < d, 2r+b < 2d, so a single
  // conditional subtraction yields (2r+b) mod d. The sum needs 5 bits
  // (up to 2*15+1) before it is folded back into the 4-bit residue.
  generate
    for (genvar i = 0; i < NDIV; i++) begin : g_chan
      localparam logic [4:0] DIV = 5'(i + 2);
      logic [4:0] w_sum;
      assign w_sum     = {res_q[i], w_bit};
      assign w_step[i] = (w_sum >= DIV) ? 4'(w_sum - DIV) : w_sum[3:0];
      // LED is MSB-first: divisor 2 lands on the top bit.
      assign w_zero[NDIV-1-i] = (w_step[i] == 4'd0);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    led_d   = led_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d   = num;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = w_step;
        num_d = {num_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: the result comes from the residues being written now,
          // not the ones currently held.
          led_d   = w_zero;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      led_q   <= led_d;
    end
  end

`ifdef NUMDET_ALL_EN
  logic all_div_q, all_div_d;

  always_comb begin
    all_div_d = all_div_q;
    if (state_q == SHIFT && cnt_q == CNT_W'(WIDTH - 1)) begin
      all_div_d = &w_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      all_div_q <= 1'b0;
    end else begin
      all_div_q <= all_div_d;
    end
  end

  assign all_div = all_div_q;
`endif

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign LED  = led_q;

endmodule
`default_nettype wire
